// File: rtl/huffman_pkg.sv
// Shared sizing, table-entry layout and encoder state encoding for the Huffman byte encoder.
// Entry i of the code table is {len, code} with the code right-aligned in its field.
package huffman_pkg;

    localparam int unsigned NUM_SYM  = 10;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned CODE_W   = 9;
    localparam int unsigned ENTRY_W  = LEN_W + CODE_W;
    localparam int unsigned TABLE_W  = NUM_SYM * ENTRY_W;
    localparam int unsigned SYM_W    = 4;

    localparam int unsigned CODE_LSB = 0;
    localparam int unsigned LEN_LSB  = CODE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_SHIFT,
        ST_FLUSH,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/huffman_bit_packer.sv
// Collects serial code bits MSB-first into bytes; on flush, zero-pads any partial byte
// and reports how many pad bits were inserted.
module huffman_bit_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_en,
    input  logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [2:0] pad_bits
);

    logic [6:0] acc;
    logic [2:0] count;
    logic [7:0] acc_ext;
    logic [7:0] pad_byte;

    // acc holds the pending `count` bits right-aligned; left-justify them for the final byte.
    always_comb begin
        acc_ext  = {1'b0, acc};
        pad_byte = acc_ext << (4'd8 - {1'b0, count});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            count      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            pad_bits   <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (bit_en) begin
                if (count == 3'd7) begin
                    byte_out   <= {acc, bit_in};
                    byte_valid <= 1'b1;
                    acc        <= '0;
                    count      <= '0;
                end else begin
                    acc   <= {acc[5:0], bit_in};
                    count <= count + 3'd1;
                end
            end else if (flush) begin
                if (count != 3'd0) begin
                    byte_out   <= pad_byte;
                    byte_valid <= 1'b1;
                    pad_bits   <= 3'(4'd8 - {1'b0, count});
                end else begin
                    pad_bits <= '0;
                end
                acc   <= '0;
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/huffman_byte_encoder.sv
// Latches the code table once it is valid, then serialises each accepted symbol's code
// one bit per clock into the packer, flushing the final partial byte on the last symbol.
module huffman_byte_encoder
    import huffman_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic [TABLE_W-1:0] CODE_TABLE,
    input  logic               over,
    input  logic               sym_valid,
    input  logic [SYM_W-1:0]   sym,
    input  logic               sym_last,
    output logic               sym_ready,
    output logic               byte_valid,
    output logic [7:0]         byte_out,
    output logic [2:0]         pad_bits,
    output logic               err,
    output logic               done
);

    enc_state_t          state, state_next;
    logic [TABLE_W-1:0]  table_q;
    logic [CODE_W-1:0]   shifter;
    logic [LEN_W-1:0]    remaining;
    logic                last_q;

    logic [ENTRY_W-1:0]  sel_entry;
    logic [LEN_W-1:0]    sel_len;
    logic [CODE_W-1:0]   sel_code;
    logic [LEN_W-1:0]    sel_shamt;
    logic                sym_bad;

    logic                accept;
    logic                bit_en;
    logic                flush;

    // Out-of-range indices select an all-zero entry, which the length check rejects.
    always_comb begin
        sel_entry = '0;
        for (int unsigned i = 0; i < NUM_SYM; i++) begin
            if (sym == SYM_W'(i)) begin
                sel_entry = table_q[ENTRY_W*i +: ENTRY_W];
            end
        end
        sel_len   = sel_entry[LEN_LSB +: LEN_W];
        sel_code  = sel_entry[CODE_LSB +: CODE_W];
        sel_shamt = LEN_W'(CODE_W) - sel_len;
        sym_bad   = (32'(sym) >= NUM_SYM) || (sel_len == '0) || (32'(sel_len) > CODE_W);
    end

    always_comb begin
        state_next = state;
        sym_ready  = 1'b0;
        accept     = 1'b0;
        bit_en     = 1'b0;
        flush      = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (over) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_READY;
            end
            ST_READY: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    accept = 1'b1;
                    if (sym_bad) begin
                        if (sym_last) state_next = ST_FLUSH;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                bit_en = 1'b1;
                if (remaining == LEN_W'(1)) begin
                    state_next = last_q ? ST_FLUSH : ST_READY;
                end
            end
            ST_FLUSH: begin
                flush      = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            table_q   <= '0;
            shifter   <= '0;
            remaining <= '0;
            last_q    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            err   <= accept && sym_bad;
            if (state == ST_LOAD) begin
                table_q <= CODE_TABLE;
            end
            if (accept && !sym_bad) begin
                // Left-justify the code so the shifter MSB is always the next bit to send.
                shifter   <= sel_code << sel_shamt;
                remaining <= sel_len;
                last_q    <= sym_last;
            end else if (bit_en) begin
                shifter   <= shifter << 1;
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    huffman_bit_packer u_packer (
        .clk        (CLK),
        .rst_n      (nRST),
        .bit_in     (shifter[CODE_W-1]),
        .bit_en     (bit_en),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .pad_bits   (pad_bits)
    );

endmodule

// File: tb/tb_huffman_byte_encoder.sv
// Self-checking bench: directed and random messages checked against a bit-list model.
module tb_huffman_byte_encoder;
    import huffman_pkg::*;

    logic               CLK = 1'b0;
    logic               nRST;
    logic [TABLE_W-1:0] CODE_TABLE;
    logic               over;
    logic               sym_valid;
    logic [3:0]         sym;
    logic               sym_last;
    logic               sym_ready;
    logic               byte_valid;
    logic [7:0]         byte_out;
    logic [2:0]         pad_bits;
    logic               err;
    logic               done;

    huffman_byte_encoder dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .CODE_TABLE (CODE_TABLE),
        .over       (over),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .pad_bits   (pad_bits),
        .err        (err),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [7:0]  got_q[$];
    int unsigned err_seen = 0;

    always @(negedge CLK) begin
        if (byte_valid) got_q.push_back(byte_out);
        if (err) err_seen++;
    end

    int unsigned tlen[16];
    int unsigned tcode[16];
    int unsigned msg_q[$];
    logic [7:0]  exp_q[$];
    int unsigned exp_pad;
    int unsigned exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sym_ok(input int unsigned s);
        return (s < NUM_SYM) && (tlen[s] >= 1) && (tlen[s] <= CODE_W);
    endfunction

    function automatic logic [TABLE_W-1:0] pack_table();
        logic [TABLE_W-1:0] t;
        t = '0;
        for (int i = 0; i < int'(NUM_SYM); i++) begin
            t[ENTRY_W*i +: ENTRY_W] = {4'(tlen[i]), 9'(tcode[i])};
        end
        return t;
    endfunction

    task automatic set_std_table();
        for (int i = 0; i < 16; i++) begin
            tlen[i]  = 4;
            tcode[i] = i;
        end
        tlen[0] = 2; tcode[0] = 'b10;
        tlen[1] = 3; tcode[1] = 'b011;
        tlen[2] = 9; tcode[2] = 'b101010101;
    endtask

    task automatic set_rand_table();
        for (int i = 0; i < 16; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)      tlen[i] = 0;
            else if (r == 1) tlen[i] = $urandom_range(10, 15);
            else             tlen[i] = $urandom_range(1, 9);
            tcode[i] = $urandom_range(0, 511);
            if (tlen[i] <= 9) tcode[i] = tcode[i] % (1 << tlen[i]);
        end
    endtask

    // Reference: concatenate code bits as a flat list, then cut into zero-padded bytes.
    task automatic build_expect();
        bit bits[$];
        exp_q.delete();
        exp_err = 0;
        foreach (msg_q[k]) begin
            int unsigned s;
            s = msg_q[k];
            if (!sym_ok(s)) exp_err++;
            else for (int b = int'(tlen[s]) - 1; b >= 0; b--) bits.push_back(bit'((tcode[s] >> b) & 1));
        end
        for (int k = 0; k < bits.size(); k += 8) begin
            logic [7:0] v;
            v = '0;
            for (int j = 0; j < 8; j++) v = {v[6:0], (k + j < bits.size()) ? bits[k + j] : 1'b0};
            exp_q.push_back(v);
        end
        exp_pad = (bits.size() % 8 == 0) ? 0 : 8 - (bits.size() % 8);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1'b0; over = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; sym = '0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_outputs", {24'b0, sym_ready, byte_valid, err, done, 1'b0, pad_bits}, 32'h0);
        check_eq("rst_byte", {24'b0, byte_out}, 32'h0);
        nRST = 1'b1;
    endtask

    // Counts negedges where the watched signal is low; returns at the first negedge it is high.
    task automatic count_low(input bit watch_done, input int limit, output int n);
        n = 0;
        forever begin
            @(negedge CLK);
            if (watch_done ? done : sym_ready) return;
            n++;
            if (n >= limit) begin
                check_eq("timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic run_msg(input string tag);
        int unsigned base_b, base_e, n_got;
        int n;
        do_reset();
        build_expect();
        base_b = got_q.size();
        base_e = err_seen;
        CODE_TABLE = pack_table();
        @(posedge CLK); #1;
        over = 1'b1;
        count_low(1'b0, 20, n);
        check_eq({tag, "_load_lat"}, 32'(n), 32'd2);
        // The table is latched already; later changes and over dropping must be ignored.
        over = 1'($urandom);
        CODE_TABLE = {$urandom, $urandom, $urandom, $urandom, $urandom};
        foreach (msg_q[k]) begin
            int unsigned s;
            logic last;
            s = msg_q[k];
            last = (k == msg_q.size() - 1);
            sym_valid = 1'b1; sym = 4'(s); sym_last = last;
            @(posedge CLK); #1;
            sym_valid = 1'b0; sym_last = 1'b0; sym = 4'($urandom);
            if (!last) begin
                count_low(1'b0, 20, n);
                check_eq({tag, "_busy"}, 32'(n), sym_ok(s) ? tlen[s] : 32'd0);
            end else begin
                count_low(1'b1, 30, n);
                check_eq({tag, "_done_lat"}, 32'(n), sym_ok(s) ? tlen[s] + 1 : 32'd1);
            end
        end
        repeat (3) @(negedge CLK);
        check_eq({tag, "_done_hold"}, {30'b0, done, sym_ready}, 32'b10);
        check_eq({tag, "_pad"}, 32'(pad_bits), exp_pad);
        check_eq({tag, "_errs"}, err_seen - base_e, exp_err);
        n_got = got_q.size() - base_b;
        check_eq({tag, "_nbytes"}, n_got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < int'(n_got); i++) begin
            check_eq({tag, "_byte"}, 32'(got_q[base_b + i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int n, bad_cycles;
        int unsigned base_b;
        nRST = 1'b0; over = 1'b0; sym_valid = 1'b0; sym = '0; sym_last = 1'b0; CODE_TABLE = '0;

        set_std_table();
        msg_q = '{0, 1};          run_msg("t1");
        msg_q = '{0, 0, 0, 0};    run_msg("t2");
        msg_q = '{2};             run_msg("t3");
        msg_q = '{12, 0};         run_msg("t4");
        msg_q = '{15};            run_msg("t4b");

        // No table yet: symbols must be ignored silently.
        do_reset();
        CODE_TABLE = pack_table();
        bad_cycles = 0;
        @(posedge CLK); #1;
        sym_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sym = 4'($urandom); sym_last = 1'($urandom);
            @(negedge CLK);
            if (sym_ready || byte_valid || err || done) bad_cycles++;
        end
        check_eq("t5_idle_quiet", 32'(bad_cycles), 32'd0);
        @(posedge CLK); #1;
        sym_valid = 1'b0; sym_last = 1'b0; over = 1'b1;
        count_low(1'b0, 20, n);
        check_eq("t5_load_lat", 32'(n), 32'd2);

        // Reset mid-SHIFT discards the partial byte.
        msg_q = '{2};
        do_reset();
        CODE_TABLE = pack_table();
        base_b = got_q.size();
        @(posedge CLK); #1;
        over = 1'b1;
        count_low(1'b0, 20, n);
        sym_valid = 1'b1; sym = 4'd2; sym_last = 1'b1;
        @(posedge CLK); #1;
        sym_valid = 1'b0; sym_last = 1'b0;
        repeat (4) @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        check_eq("t6_rst_outputs", {24'b0, sym_ready, byte_valid, err, done, 1'b0, pad_bits}, 32'h0);
        nRST = 1'b1; over = 1'b0;
        repeat (15) @(negedge CLK);
        check_eq("t6_no_bytes", got_q.size() - base_b, 32'd0);
        check_eq("t6_idle", {30'b0, done, sym_ready}, 32'd0);

        for (int m = 0; m < 30; m++) begin
            int unsigned len;
            set_rand_table();
            msg_q.delete();
            len = $urandom_range(1, 8);
            for (int k = 0; k < int'(len); k++) msg_q.push_back($urandom_range(0, 11));
            run_msg("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
